user_pulser_sequencer: RTL and testbench
========================================

# user_pulser_sequencer

Programmable step sequencer that drives the start/stop inputs of `N_PULSER_INST` pulser instances. It walks a small step table with optional looping; each step issues start/stop masks, waits a fixed delay, then waits until selected pulsers report ready. It sits beside the pulser wrapper on the user-domain OBI bus as its own OBI subordinate. Its `start_o`/`stop_o` are OR-ed into the pulser command pulses, and the pulser ready bits feed back into `ready_i`.

## Interface
- `ObiCfg`, default `obi_pkg::ObiDefaultConfig`: OBI bus configuration.
- `obi_req_t`, default `logic`: OBI request type.
- `obi_rsp_t`, default `logic`: OBI response type.
- `N_PULSER_INST`, default 4: number of controlled pulsers, 1..8.
- `N_STEPS`, default 8: step table depth, power of two, 2..16.
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `obi_req_i`  in  obi_req_t  OBI request.
- `obi_rsp_o`  out  obi_rsp_t  OBI response.
- `ready_i`  in  N_PULSER_INST  per-pulser ready (pulser in IDLE or DONE).
- `start_o`  out  N_PULSER_INST  one-cycle start pulses.
- `stop_o`  out  N_PULSER_INST  one-cycle stop pulses.
- `busy_o`  out  1  sequence running.
- `done_irq_o`  out  1  one-cycle pulse when a sequence completes normally.

## Operation
- **OBI protocol**
  - `gnt` = `req` in the same cycle.
  - `rvalid` and `rid` follow one cycle later.
  - Writes take effect in the `rvalid` cycle.
- **Register map** (byte offsets)
  - 0x00 CTRL, write-only: bit0 RUN, bit1 ABORT. Reads return 0.
  - 0x04 LOOP: bits[7:0] repeat count, read/write.
  - 0x08 STATUS, read-only: bit0 busy; [7:4] current step index; [15:8] loops remaining.
  - 0x40 + 4·k STEP[k]: [7:0] start mask; [15:8] stop mask; [23:16] wait mask; [30:24] delay; [31] LAST.
  - Mask bits ≥ `N_PULSER_INST` are stored but ignored.
- **Errors**
  - An unmapped offset returns `err=1` and `rdata=0`.
  - A write to STEP or LOOP while busy returns `err=1`, and the write is dropped.
- **FSM states**
  - IDLE: RUN loads loops-remaining from LOOP and index 0, then goes to ISSUE. RUN while busy is ignored.
  - ISSUE (1 cycle): `start_o` = step.start, `stop_o` = step.stop. Then goes to DELAY.
  - DELAY: lasts max(delay,1) cycles. The minimum of 1 guarantees ready is sampled ≥2 cycles after ISSUE. Then goes to WAIT.
  - WAIT: leaves in the first cycle where (`ready_i` & wait) == wait. A wait mask of 0 leaves WAIT in 1 cycle.
    - If LAST is set or index == `N_STEPS`-1: when loops-remaining > 0, decrement it, set index 0 and go to ISSUE. Otherwise pulse `done_irq_o` and go to IDLE.
    - Otherwise, index+1 and go to ISSUE.
- **ABORT** (any non-IDLE state): for one cycle `stop_o` = all ones and `start_o` = 0, then IDLE. No irq.
  - RUN and ABORT in the same write: ABORT wins. If IDLE, nothing happens.
- `busy_o` = (state != IDLE).

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; index 0; LOOP 0; all STEP entries 0.
  - `rvalid` 0.
- RUN write granted at cycle T:
  - T+1: `rvalid` and CTRL update; `busy_o` = 1.
  - T+2: ISSUE; `start_o` asserted.
- One step with delay d and an already-satisfied wait takes 1 + max(d,1) + 1 cycles.
- `done_irq_o` asserts in the cycle after the final WAIT exit; `busy_o` is 0 in that same cycle.
- Asynchronous reset mid-sequence returns everything to reset values immediately. No stop pulse is issued.

## Structure
- Package `user_pulser_seq_pkg` holds:
  - `step_t` packed struct;
  - `seq_state_e` enum;
  - register offset localparams;
  - field widths.
- Sub-module `user_pulser_seq_regs`: OBI subordinate plus register file. It exports the step table, LOOP and RUN/ABORT strobes, and takes busy/status as inputs.
- The top level holds the FSM, the delay counter and the loop counter.

## Test plan
- **Reset:** all outputs 0; reads of 0x04, 0x08 and 0x40 return 0; no OBI `err`.
- **Two-step program**
  - Setup: STEP0 = 0x0100_0001 (start p0, delay 1); STEP1 = 0x8002_0002 (start p1, wait p1, LAST); `ready_i`=0xF; RUN at T.
  - Response: `start_o`=0x1 at T+2 and 0x2 at T+5.
  - Hold `ready_i[1]`=0 for 5 cycles, then release → one `done_irq_o` pulse, then `busy_o`=0.
- **Loop:** LOOP=2, STEP0 = 0x8000_0001 → exactly 3 `start_o`=0x1 pulses, then 1 irq. STATUS[15:8] reads 2, 1, 0 across iterations.
- **Abort:** ABORT while in WAIT → `stop_o`=0xF for 1 cycle, `busy_o`=0 next cycle, no irq.
- **Write errors:**
  - A write to STEP3 while busy → `err`=1 and STEP3 unchanged.
  - A read of 0x14 → `err`=1, `rdata`=0.
- **Wrap:** no LAST bits set, `N_STEPS`=8, LOOP=0 → 8 ISSUE cycles with indices 0..7, then done.

Source files
------------

// File: rtl/user_pulser_seq_pkg.sv
// user_pulser_seq_pkg: step/FSM types, register map and the default OBI bundle
// shared by the pulser sequencer and its register block.
package user_pulser_seq_pkg;

    localparam int unsigned MASK_W  = 8;
    localparam int unsigned DELAY_W = 7;
    localparam int unsigned LOOP_W  = 8;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_LOOP   = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_STEP   = 8'h40;

    typedef struct packed {
        logic               last;
        logic [DELAY_W-1:0] delay;
        logic [MASK_W-1:0]  wait_mask;
        logic [MASK_W-1:0]  stop;
        logic [MASK_W-1:0]  start;
    } step_t;

    // ARM gives the RUN write its rvalid cycle before the first ISSUE.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_ISSUE,
        ST_DELAY,
        ST_WAIT,
        ST_ABORT
    } seq_state_e;

    typedef struct packed {
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{IdWidth: 1};

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } seq_obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } seq_obi_rsp_t;

    function automatic logic [31:0] apply_be(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) old_v[8*b +: 8] = new_v[8*b +: 8];
        return old_v;
    endfunction

endpackage

// File: rtl/user_pulser_seq_regs.sv
// user_pulser_seq_regs: OBI subordinate holding the step table and LOOP register,
// issuing RUN/ABORT strobes and reporting sequencer status.
module user_pulser_seq_regs
    import user_pulser_seq_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg    = ObiDefaultConfig,
    parameter type         obi_req_t = seq_obi_req_t,
    parameter type         obi_rsp_t = seq_obi_rsp_t,
    parameter int unsigned N_STEPS   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  obi_req_t                  obi_req_i,
    output obi_rsp_t                  obi_rsp_o,
    input  logic                      busy_i,
    input  logic [3:0]                step_idx_i,
    input  logic [LOOP_W-1:0]         loops_rem_i,
    output step_t [N_STEPS-1:0]       steps_o,
    output logic [LOOP_W-1:0]         loop_o,
    output logic                      run_o,
    output logic                      abort_o
);

    localparam int unsigned SW = $clog2(N_STEPS);

    step_t [N_STEPS-1:0]       steps_q;
    logic [LOOP_W-1:0]         loop_q;
    logic                      rvalid_q;
    logic                      err_q;
    logic [31:0]               rdata_q;
    logic [31:0]               rdata_d;
    logic [ObiCfg.IdWidth-1:0] rid_q;
    logic [5:0]                word;
    logic [SW-1:0]             k;
    logic                      is_ctrl;
    logic                      is_loop;
    logic                      is_status;
    logic                      is_step;
    logic                      err_d;
    logic                      wr_ok;
    logic                      unused_addr;

    // The block decodes a 256-byte window; base bits and byte lanes are don't-care.
    assign word        = obi_req_i.addr[7:2];
    assign unused_addr = ^{obi_req_i.addr[31:8], obi_req_i.addr[1:0]};
    assign k           = word[SW-1:0];
    assign is_ctrl     = word == OFF_CTRL[7:2];
    assign is_loop     = word == OFF_LOOP[7:2];
    assign is_status   = word == OFF_STATUS[7:2];
    assign is_step     = (word[5:4] == OFF_STEP[7:6]) && ({1'b0, word[3:0]} < 5'(N_STEPS));

    assign err_d   = !(is_ctrl || is_loop || is_status || is_step)
                   || (obi_req_i.we && busy_i && (is_loop || is_step));
    assign wr_ok   = obi_req_i.req && obi_req_i.we && !err_d;
    assign run_o   = wr_ok && is_ctrl && obi_req_i.be[0] && obi_req_i.wdata[0];
    assign abort_o = wr_ok && is_ctrl && obi_req_i.be[0] && obi_req_i.wdata[1];

    assign rdata_d = (err_d || obi_req_i.we) ? '0
                   : is_loop   ? 32'(loop_q)
                   : is_status ? {16'h0, loops_rem_i, step_idx_i, 3'b000, busy_i}
                   : is_step   ? steps_q[k]
                   : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            loop_q   <= '0;
            steps_q  <= '0;
        end else begin
            rvalid_q <= obi_req_i.req;
            if (obi_req_i.req) begin
                err_q   <= err_d;
                rdata_q <= rdata_d;
                rid_q   <= obi_req_i.aid;
            end
            if (wr_ok && is_loop && obi_req_i.be[0]) loop_q <= obi_req_i.wdata[LOOP_W-1:0];
            if (wr_ok && is_step) steps_q[k] <= apply_be(steps_q[k], obi_req_i.wdata, obi_req_i.be);
        end
    end

    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = obi_req_i.req;
        obi_rsp_o.rvalid = rvalid_q;
        obi_rsp_o.rdata  = rdata_q;
        obi_rsp_o.rid    = rid_q;
        obi_rsp_o.err    = err_q;
    end

    assign steps_o = steps_q;
    assign loop_o  = loop_q;

endmodule

// File: rtl/user_pulser_sequencer.sv
// user_pulser_sequencer: walks an OBI-programmed step table, pulsing pulser
// start/stop commands, waiting on delays and ready bits, with looping and abort.
module user_pulser_sequencer
    import user_pulser_seq_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg        = ObiDefaultConfig,
    parameter type         obi_req_t     = seq_obi_req_t,
    parameter type         obi_rsp_t     = seq_obi_rsp_t,
    parameter int unsigned N_PULSER_INST = 4,
    parameter int unsigned N_STEPS       = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  obi_req_t                 obi_req_i,
    output obi_rsp_t                 obi_rsp_o,
    input  logic [N_PULSER_INST-1:0] ready_i,
    output logic [N_PULSER_INST-1:0] start_o,
    output logic [N_PULSER_INST-1:0] stop_o,
    output logic                     busy_o,
    output logic                     done_irq_o
);

    localparam int unsigned       SW         = $clog2(N_STEPS);
    localparam logic [MASK_W-1:0] VALID_MASK = MASK_W'((16'd1 << N_PULSER_INST) - 16'd1);

    seq_state_e          state_q, state_d;
    logic [SW-1:0]       idx_q, idx_d;
    logic [DELAY_W-1:0]  cnt_q, cnt_d;
    logic [LOOP_W-1:0]   loops_q, loops_d;
    logic                done_q, done_d;
    step_t [N_STEPS-1:0] steps;
    step_t               cur;
    logic [LOOP_W-1:0]   loop_cfg;
    logic                run;
    logic                abort;
    logic [MASK_W-1:0]   wait_eff;
    logic                wait_ok;
    logic                is_last;

    user_pulser_seq_regs #(
        .ObiCfg    (ObiCfg),
        .obi_req_t (obi_req_t),
        .obi_rsp_t (obi_rsp_t),
        .N_STEPS   (N_STEPS)
    ) u_regs (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .obi_req_i   (obi_req_i),
        .obi_rsp_o   (obi_rsp_o),
        .busy_i      (busy_o),
        .step_idx_i  (4'(idx_q)),
        .loops_rem_i (loops_q),
        .steps_o     (steps),
        .loop_o      (loop_cfg),
        .run_o       (run),
        .abort_o     (abort)
    );

    // Wait bits for pulsers that do not exist are treated as always ready.
    assign cur      = steps[idx_q];
    assign wait_eff = cur.wait_mask & VALID_MASK;
    assign wait_ok  = (MASK_W'(ready_i) & wait_eff) == wait_eff;
    assign is_last  = cur.last || (idx_q == SW'(N_STEPS - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        loops_d = loops_q;
        done_d  = 1'b0;
        start_o = '0;
        stop_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (run && !abort) begin
                    state_d = ST_ARM;
                    idx_d   = '0;
                    loops_d = loop_cfg;
                end
            end
            ST_ARM: state_d = ST_ISSUE;
            ST_ISSUE: begin
                start_o = N_PULSER_INST'(cur.start);
                stop_o  = N_PULSER_INST'(cur.stop);
                cnt_d   = (cur.delay == '0) ? DELAY_W'(1) : cur.delay;
                state_d = ST_DELAY;
            end
            ST_DELAY: begin
                cnt_d   = cnt_q - DELAY_W'(1);
                state_d = (cnt_q == DELAY_W'(1)) ? ST_WAIT : ST_DELAY;
            end
            ST_WAIT: begin
                if (wait_ok && !is_last) begin
                    idx_d   = idx_q + SW'(1);
                    state_d = ST_ISSUE;
                end else if (wait_ok && loops_q != '0) begin
                    loops_d = loops_q - LOOP_W'(1);
                    idx_d   = '0;
                    state_d = ST_ISSUE;
                end else if (wait_ok) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                stop_o  = '1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE && state_q != ST_ABORT) begin
            state_d = ST_ABORT;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            loops_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            loops_q <= loops_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = state_q != ST_IDLE;
    assign done_irq_o = done_q;

endmodule

// File: tb/tb_user_pulser_sequencer.sv
// tb_user_pulser_sequencer: register-map vector table plus timed sequences for
// run, loop, abort, wrap and asynchronous reset of the pulser sequencer.
module tb_user_pulser_sequencer;
    import user_pulser_seq_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    seq_obi_req_t req;
    seq_obi_rsp_t rsp;
    logic [3:0]   ready;
    logic [3:0]   start;
    logic [3:0]   stop;
    logic         busy;
    logic         irq;
    int           checks = 0;
    int           fails = 0;
    int           start_cnt = 0;
    int           irq_cnt = 0;
    vec_t         vt[15];

    user_pulser_sequencer dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .obi_req_i  (req),
        .obi_rsp_o  (rsp),
        .ready_i    (ready),
        .start_o    (start),
        .stop_o     (stop),
        .busy_o     (busy),
        .done_irq_o (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start != 4'h0) start_cnt++;
        if (irq) irq_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic obi(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        req.req   = 1'b1;
        req.we    = we;
        req.addr  = addr;
        req.wdata = wdata;
        req.be    = 4'hF;
        req.aid   = 1'b1;
        #1 chk("gnt", 32'(rsp.gnt), 1);
        @(negedge clk);
        req.req = 1'b0;
        chk("rvalid", 32'(rsp.rvalid), 1);
        chk("rid", 32'(rsp.rid), 1);
        rdata = rsp.rdata;
        err   = rsp.err;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        logic        e;
        obi(1'b1, addr, data, d, e);
        chk($sformatf("wr_err@%0h", addr), 32'(e), 0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] d;
        logic        e;
        obi(1'b0, addr, 32'h0, d, e);
        chk(name, d, exp);
        chk({name, "_err"}, 32'(e), 0);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          bi;
        int          bs;
        req   = '0;
        ready = 4'hF;
        vt[0]  = '{1'b0, 32'h04, 32'h0,         32'h0,        1'b0};
        vt[1]  = '{1'b0, 32'h08, 32'h0,         32'h0,        1'b0};
        vt[2]  = '{1'b0, 32'h40, 32'h0,         32'h0,        1'b0};
        vt[3]  = '{1'b0, 32'h00, 32'h0,         32'h0,        1'b0};
        vt[4]  = '{1'b0, 32'h14, 32'h0,         32'h0,        1'b1};
        vt[5]  = '{1'b1, 32'h04, 32'h1234_56A5, 32'h0,        1'b0};
        vt[6]  = '{1'b0, 32'h04, 32'h0,         32'hA5,       1'b0};
        vt[7]  = '{1'b1, 32'h4C, 32'hDEAD_BEEF, 32'h0,        1'b0};
        vt[8]  = '{1'b0, 32'h4C, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[9]  = '{1'b0, 32'h5C, 32'h0,         32'h0,        1'b0};
        vt[10] = '{1'b0, 32'h60, 32'h0,         32'h0,        1'b1};
        vt[11] = '{1'b1, 32'h14, 32'hFFFF,      32'h0,        1'b1};
        vt[12] = '{1'b1, 32'h4C, 32'h0,         32'h0,        1'b0};
        vt[13] = '{1'b1, 32'h04, 32'h0,         32'h0,        1'b0};
        vt[14] = '{1'b0, 32'h0C, 32'h0,         32'h0,        1'b1};

        repeat (2) @(negedge clk);
        chk("rst_start", 32'(start), 0);
        chk("rst_stop", 32'(stop), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_rvalid", 32'(rsp.rvalid), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            obi(vt[i].we, vt[i].addr, vt[i].wdata, d, e);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].err));
            if (!vt[i].we) chk($sformatf("vec%0d_rdata", i), d, vt[i].rdata);
        end

        // two-step program: start p0, then start p1 and wait for it
        wr(32'h40, 32'h0100_0001);
        wr(32'h44, 32'h8002_0002);
        bi = irq_cnt;
        obi(1'b1, 32'h00, 32'h1, d, e);
        chk("run_busy_t1", 32'(busy), 1);
        chk("run_start_t1", 32'(start), 0);
        @(negedge clk);
        chk("run_start_t2", 32'(start), 1);
        @(negedge clk);
        chk("run_start_t3", 32'(start), 0);
        @(negedge clk);
        chk("run_start_t4", 32'(start), 0);
        @(negedge clk);
        chk("run_start_t5", 32'(start), 2);
        ready = 4'hD;
        repeat (5) begin
            @(negedge clk);
            chk("hold_busy", 32'(busy), 1);
            chk("hold_irq", 32'(irq), 0);
        end
        ready = 4'hF;
        @(negedge clk);
        chk("done_irq", 32'(irq), 1);
        chk("done_busy", 32'(busy), 0);
        @(negedge clk);
        chk("done_irq_pulse", 32'(irq), 0);
        chk("done_irq_count", 32'(irq_cnt - bi), 1);

        // loop: three iterations of a single LAST step
        wr(32'h04, 32'h2);
        wr(32'h40, 32'h8000_0001);
        bi = irq_cnt;
        bs = start_cnt;
        obi(1'b1, 32'h00, 32'h1, d, e);
        rd(32'h08, 32'h0201, "status_iter0");
        repeat (3) @(negedge clk);
        rd(32'h08, 32'h0101, "status_iter1");
        repeat (2) @(negedge clk);
        rd(32'h08, 32'h0001, "status_iter2");
        for (int i = 0; i < 20 && irq_cnt == bi; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("loop_irqs", 32'(irq_cnt - bi), 1);
        chk("loop_starts", 32'(start_cnt - bs), 3);
        chk("loop_busy", 32'(busy), 0);
        wr(32'h04, 32'h0);

        // abort while stuck in WAIT, with refused writes first
        wr(32'h40, 32'h8001_0001);
        ready = 4'h0;
        bi = irq_cnt;
        obi(1'b1, 32'h00, 32'h1, d, e);
        repeat (3) @(negedge clk);
        obi(1'b1, 32'h4C, 32'h1111_1111, d, e);
        chk("busy_step_wr_err", 32'(e), 1);
        obi(1'b1, 32'h04, 32'h5, d, e);
        chk("busy_loop_wr_err", 32'(e), 1);
        chk("still_busy", 32'(busy), 1);
        obi(1'b1, 32'h00, 32'h3, d, e);
        chk("abort_stop", 32'(stop), 32'hF);
        chk("abort_start", 32'(start), 0);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_stop_end", 32'(stop), 0);
        chk("abort_no_irq", 32'(irq_cnt - bi), 0);
        rd(32'h4C, 32'h0, "step3_unchanged");
        rd(32'h04, 32'h0, "loop_unchanged");
        obi(1'b1, 32'h00, 32'h2, d, e);
        chk("idle_abort_stop", 32'(stop), 0);
        @(negedge clk);
        chk("idle_abort_busy", 32'(busy), 0);
        ready = 4'hF;

        // wrap: no LAST bits, table runs through all 8 entries
        for (int k = 0; k < 8; k++) wr(32'h40 + 32'(4 * k), 32'hF0 | 32'(k + 1));
        obi(1'b1, 32'h00, 32'h1, d, e);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("wrap_start%0d", k), 32'(start), 32'(k + 1));
            @(negedge clk);
            @(negedge clk);
        end
        @(negedge clk);
        chk("wrap_irq", 32'(irq), 1);
        chk("wrap_busy", 32'(busy), 0);

        // asynchronous reset in the middle of a long delay
        wr(32'h40, 32'h8501_0001);
        obi(1'b1, 32'h00, 32'h1, d, e);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_stop", 32'(stop), 0);
        chk("arst_start", 32'(start), 0);
        chk("arst_irq", 32'(irq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(32'h40, 32'h0, "arst_step0");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
